// File: rtl/sm_mdu_pkg.sv
// Shared definitions for the schoolMIPS multiply/divide unit:
// operation codes, FSM state encoding, and the funct codes that
// sm_control decodes for the HI/LO instruction group.
package sm_mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/sm_mdu_abs.sv
// Conditional two's-complement negation. Used both to take operand
// magnitudes and to restore result signs.
//   value  : input word
//   neg    : 1 = output -value, 0 = pass through
//   result : conditionally negated word
module sm_mdu_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/sm_mdu.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
//
// state    | meaning
// ---------+------------------------------------------------------
// MDU_IDLE | waiting for start; MTHI/MTLO complete here in one edge
// MDU_CALC | one shift-add / restoring-divide step per edge
// MDU_FIX  | sign fixup, HI/LO write, done pulse
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, oper       request and MDU_* op code (sampled while idle)
//   srcA, srcB        operands
//   flush             cancel an operation in flight
//   busy, done        in-progress flag, one-cycle completion pulse
//   hi, lo            result registers
module sm_mdu
  import sm_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               div0_q, div0_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   m_q, m_d;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   orig_q, orig_d;  // raw dividend for divide-by-zero
  logic [2*WIDTH-1:0] prod_q, prod_d;  // product, or {remainder, quotient}
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] fix_lo_in, fix_lo_out;
  logic [WIDTH-1:0]   fix_hi_out;

  assign neg_a = mdu_is_signed(oper) & srcA[WIDTH-1];
  assign neg_b = mdu_is_signed(oper) & srcB[WIDTH-1];

  sm_mdu_abs #(.WIDTH(WIDTH)) u_abs_a (.value(srcA), .neg(neg_a), .result(mag_a));
  sm_mdu_abs #(.WIDTH(WIDTH)) u_abs_b (.value(srcB), .neg(neg_b), .result(mag_b));

  // Shift-add: the multiplier sits in the low half and is consumed LSB first.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
  assign mul_step = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]}
                              : {1'b0, prod_q[2*WIDTH-1:1]};

  // Restoring step: the remainder never reaches the divisor, so the
  // W-bit subtraction is exact whenever the trial succeeds.
  assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, m_q};
  assign div_sub   = div_shift[WIDTH-1:0] - m_q;
  assign div_step  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]),
                      prod_q[WIDTH-2:0], div_ge};

  // The low-result fixup is double width so a product negates as a whole.
  assign fix_lo_in = div_q ? {{WIDTH{1'b0}}, prod_q[WIDTH-1:0]} : prod_q;

  sm_mdu_abs #(.WIDTH(2*WIDTH)) u_fix_lo (.value(fix_lo_in), .neg(neg_res_q),
                                          .result(fix_lo_out));
  sm_mdu_abs #(.WIDTH(WIDTH)) u_fix_hi (.value(prod_q[2*WIDTH-1:WIDTH]),
                                        .neg(neg_rem_q), .result(fix_hi_out));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    div0_d    = div0_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    m_d       = m_q;
    orig_d    = orig_q;
    prod_d    = prod_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      MDU_IDLE: begin
        if (start && !flush) begin
          case (oper)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d   = MDU_CALC;
              cnt_d     = '0;
              div_d     = mdu_is_div(oper);
              div0_d    = (srcB == '0);
              neg_res_d = neg_a ^ neg_b;
              neg_rem_d = neg_a;
              orig_d    = srcA;
              m_d       = mdu_is_div(oper) ? mag_b : mag_a;
              prod_d    = {{WIDTH{1'b0}}, (mdu_is_div(oper) ? mag_a : mag_b)};
            end
            MDU_MTHI: begin
              hi_d   = srcA;
              done_d = 1'b1;
            end
            MDU_MTLO: begin
              lo_d   = srcA;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MDU_CALC: begin
        if (flush) begin
          state_d = MDU_IDLE;
        end else begin
          prod_d = div_q ? div_step : mul_step;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) state_d = MDU_FIX;
        end
      end
      MDU_FIX: begin
        state_d = MDU_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (div_q && div0_q) begin
            lo_d = {WIDTH{1'b1}};
            hi_d = orig_q;
          end else if (div_q) begin
            lo_d = fix_lo_out[WIDTH-1:0];
            hi_d = fix_hi_out;
          end else begin
            lo_d = fix_lo_out[WIDTH-1:0];
            hi_d = fix_lo_out[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      m_q       <= '0;
      orig_q    <= '0;
      prod_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      div0_q    <= div0_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      m_q       <= m_d;
      orig_q    <= orig_d;
      prod_q    <= prod_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != MDU_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_sm_mdu.sv
module tb_sm_mdu;
  import sm_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  oper = 3'b000;
  logic [31:0] srcA = '0, srcB = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [2:0]  oper8 = 3'b000;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        flush8 = 1'b0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];
  logic [63:0] sb_e;
  logic [31:0] mhi = '0, mlo = '0;

  always #5 clk = ~clk;

  sm_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .oper(oper), .srcA(srcA),
    .srcB(srcB), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  sm_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .oper(oper8), .srcA(a8),
    .srcB(b8), .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = {h, l};
    case (op)
      MDU_MULT:  res = 64'(sa * sb);
      MDU_MULTU: res = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      MDU_DIVU:  res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      MDU_MTHI:  res = {a, l};
      MDU_MTLO:  res = {h, a};
      default: ;
    endcase
    return res;
  endfunction

  // Scoreboard: every done pulse pops one expected {hi,lo}.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) chk("sb_unexpected_done", 1, 0);
      else begin
        sb_e = exp_q.pop_front();
        chk("sb_hi", hi, sb_e[63:32]);
        chk("sb_lo", lo, sb_e[31:0]);
      end
    end
  end

  task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = model(op, a, b, mhi, mlo);
    mhi = r[63:32];
    mlo = r[31:0];
    exp_q.push_back(r);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; oper = op; srcA = a; srcB = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the current point until done, and busy-high samples.
  task automatic wait_done(input int budget, output int edges, output int bcnt);
    edges = 0;
    bcnt = busy ? 1 : 0;
    while (!done && edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (busy) bcnt++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input int exp_busy, input string tag);
    int edges, bcnt;
    push_exp(op, a, b);
    issue(op, a, b);
    wait_done(100, edges, bcnt);
    chk({tag, "_lat"}, edges, exp_lat);
    chk({tag, "_busy"}, bcnt, exp_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, bcnt, nd;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: full-width unsigned product, latency and busy span
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 33, "multu_max");
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // 2: signed multiply, then a divide started in the done cycle
    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 33, 33, "mult_neg");
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 33, "div_b2b");
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // 3: divide by zero and MIN / -1
    run_op(MDU_DIVU, 32'd100, 32'd0, 33, 33, "divu_zero");
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd100);
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 33, "div_min");
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 32'h0);

    // 4: MTHI / MTLO complete in one edge without busy
    run_op(MDU_MTHI, 32'h1234, 32'd0, 0, 0, "mthi");
    chk("mthi_hi", hi, 32'h1234);
    @(posedge clk); #1 chk("mthi_done_1cyc", done, 0);
    run_op(MDU_MTLO, 32'hABCD, 32'd0, 0, 0, "mtlo");
    chk("mtlo_lo", lo, 32'hABCD);
    chk("mtlo_hi_kept", hi, 32'h1234);
    @(posedge clk); #1 chk("mtlo_done_1cyc", done, 0);

    // undefined opcode and flush-with-start in idle are both dropped
    issue(3'b111, 32'h5555, 32'h1);
    chk("undef_busy", busy, 0);
    chk("undef_done", done, 0);
    @(negedge clk);
    start = 1'b1; flush = 1'b1; oper = MDU_MTHI; srcA = 32'hDEAD;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("idle_flush_done", done, 0);
    chk("idle_flush_hi", hi, 32'h1234);

    // a few random arithmetic ops
    for (int i = 0; i < 4; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      run_op(rop, ra, rb, 33, 33, "rand");
    end

    // 5: start while busy is ignored
    push_exp(MDU_DIVU, 32'd50, 32'd7);
    issue(MDU_DIVU, 32'd50, 32'd7);
    repeat (4) @(posedge clk);
    issue(MDU_MULT, 32'd2, 32'd3);
    chk("ign_busy", busy, 1);
    wait_done(100, edges, bcnt);
    chk("ign_lat", edges, 28);
    chk("ign_lo", lo, 32'd7);
    chk("ign_hi", hi, 32'd1);
    repeat (3) @(posedge clk);

    // flush mid-CALC: no done, HI/LO untouched
    issue(MDU_MULTU, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("flush_nodone", nd, 0);
    chk("flush_hi", hi, 32'd1);
    chk("flush_lo", lo, 32'd7);

    // 6: asynchronous reset mid-CALC
    issue(MDU_MULTU, 32'd3, 32'd3);
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    mhi = '0; mlo = '0;
    @(negedge clk) rst_n = 1'b1;

    // WIDTH=8 instance: MIN * MIN
    @(negedge clk);
    start8 = 1'b1; oper8 = MDU_MULT; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk); #1 start8 = 1'b0;
    edges = 0;
    while (!done8 && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("w8_lat", edges, 9);
    chk("w8_hi", hi8, 8'h40);
    chk("w8_lo", lo8, 8'h00);

    repeat (3) @(posedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_mdu.md
Name: sm_mdu

Overview:
Iterative multiply/divide unit for the schoolMIPS core. It provides MULT, MULTU, DIV, DIVU, MTHI and MTLO, with HI/LO result registers.
- It sits beside sm_alu. The control unit issues ops with a start/busy/done handshake.
- It is parametrised in operand width.
- Unlike the single-cycle ALU, it is multi-cycle: one radix-2 step per clock, and it holds its state between operations.

Parameters:
WIDTH, 32, operand width in bits. Legal range is 4 to 64; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on the rising clk edge while busy=0
oper  input  3  operation code (MDU_* constants)
srcA  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
srcB  input  WIDTH  multiplier / divisor
flush  input  1  synchronous cancel of an operation in progress
busy  output  1  operation in progress; start is ignored while high
done  output  1  one-cycle pulse: HI/LO have just been updated
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0.
  - State goes to IDLE, counter=0.
  - Reset mid-operation aborts the operation immediately.
- States: IDLE, CALC, FIX.
- IDLE, start=1, oper=MULT/MULTU/DIV/DIVU (edge E0):
  - Latch the operation and the operand magnitudes. Signed ops use two's-complement absolute value; unsigned ops use operands as-is.
  - Latch the result-sign flags.
  - Go to CALC, set busy=1, counter=0.
- IDLE, start=1, oper=MTHI/MTLO (edge E0):
  - Write srcA to hi or lo.
  - done=1 for the following cycle; busy stays 0; state stays IDLE.
- Undefined oper with start=1: ignored. No state change, no done.
- CALC: one step per edge; after WIDTH steps (edges E1..E_WIDTH) go to FIX.
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring step on a WIDTH-bit partial remainder and a WIDTH-bit quotient.
- FIX (edge E_WIDTH+1): apply sign correction, write hi/lo, done=1 for one cycle, busy=0, return to IDLE.
  - Latency: done is visible in the cycle after edge E_WIDTH+1, i.e. WIDTH+1 edges after the start edge. Back-to-back start is legal in the done cycle.
- Signed results:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - MIN / -1 gives lo=MIN, hi=0 (natural wrap), with no flag.
- Divide by zero (signed or unsigned): lo={WIDTH{1'b1}}, hi=original srcA. No sign fixup. Normal latency.
- Unsigned results: MULTU gives {hi,lo} = full 2*WIDTH product. DIVU gives lo=quotient, hi=remainder.
- start while busy=1: ignored; no effect on the operation in flight.
- flush=1 while busy (CALC or FIX, sampled at an edge):
  - Return to IDLE, busy=0, no done.
  - hi/lo keep their pre-operation values.
  - flush has priority over completion in the same cycle.
  - flush in IDLE has no effect; flush and start in the same IDLE cycle: flush wins and start is dropped.
- hi/lo change only on a FIX completion, MTHI/MTLO, or reset.

Decomposition:
- Add to sm_cpu.vh:
  - MDU_MULT=3'b000, MDU_MULTU=3'b001, MDU_DIV=3'b010, MDU_DIVU=3'b011, MDU_MTHI=3'b100, MDU_MTLO=3'b101.
  - State encodings MDU_IDLE=2'd0, MDU_CALC=2'd1, MDU_FIX=2'd2.
  - Function codes F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO for sm_control.
- One natural sub-module: sm_mdu_abs (parameter WIDTH; inputs value, neg; output conditionally negated value).
  - Instantiated once for each operand magnitude and once for each result fixup (4 instances in total).

Test Plan:
1. MULTU srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done pulses exactly 33 edges after the start edge; busy high for those 33 cycles.
2. MULT srcA=0xFFFFFFFD (-3), srcB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV srcA=0xFFFFFFF9 (-7), srcB=2 issued in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU srcA=100, srcB=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV srcA=0x80000000, srcB=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI srcA=0x1234 -> hi=0x1234 one edge later, done for one cycle, busy never high. Then MTLO 0xABCD -> lo=0xABCD, hi unchanged.
5. DIVU 50/7 started, then start with MULT 2*3 at iteration 5 -> ignored; result lo=7, hi=1. Then MULTU 6*7 with flush at iteration 10 -> no done, busy=0 next cycle, hi/lo still 1/7.
6. rst_n low mid-CALC (iteration 12) -> busy=0, done=0, hi=lo=0 immediately without a clock. Repeat at WIDTH=8: MULT 0x80*0x80 -> hi=0x40, lo=0x00, done 9 edges after start.
